// File: rtl/bus_reg_bank.sv
// -----------------------------------------------------------------------------
// bus_reg_bank
//   A bank of DEPTH registers, each WIDTH bits wide. The bus can write any
//   register, and can read any register with one cycle of latency. Each
//   register can also be incremented or decremented. A sticky flag records
//   every overflow and underflow.
//
//   Parameters
//     WIDTH  data width of each register and of the bus
//     DEPTH  number of registers (2..16)
//     SAT    0 = wrapping inc/dec, 1 = saturating inc/dec
//     AW     address width, clog2(DEPTH) with a minimum of 1 (derived)
//
//   Ports
//     clk     clock; all state changes on its rising edge
//     RST     asynchronous active-high reset
//     CLR     per-register synchronous clear (one bit per register)
//     WR      write enable;  WADDR = target, BIN = data
//     INC     increment request; CADDR = target
//     DEC     decrement request; CADDR = target
//     LDBUS   read request; RADDR = source
//     OVFCLR  clears the sticky overflow flag
//     BOUT    registered read data (0 when no read)
//     BVALID  BOUT holds read data
//     OVF     sticky overflow/underflow flag
// -----------------------------------------------------------------------------
module bus_reg_bank #(
    parameter  int unsigned WIDTH = 16,
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned SAT   = 0,
    localparam int unsigned AW    = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [DEPTH-1:0] CLR,
    input  logic             WR,
    input  logic [AW-1:0]    WADDR,
    input  logic [WIDTH-1:0] BIN,
    input  logic             INC,
    input  logic             DEC,
    input  logic [AW-1:0]    CADDR,
    input  logic             LDBUS,
    input  logic [AW-1:0]    RADDR,
    input  logic             OVFCLR,
    output logic [WIDTH-1:0] BOUT,
    output logic             BVALID,
    output logic             OVF
);

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic [WIDTH-1:0] w_next [DEPTH];
    logic             w_ovf_ev;
    logic [WIDTH-1:0] w_rdata;
    logic [WIDTH-1:0] r_bout;
    logic             r_bvalid;
    logic             r_ovf;

    // Next state for each register, highest priority first: clear, write,
    // count. A count is applied only when it is not overridden, so a count
    // that loses to a clear or a write can never raise the overflow flag.
    // Addresses at or above DEPTH match no register and are ignored.
    always_comb begin
        w_ovf_ev = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_next[i] = r_regs[i];
            if (CLR[i]) begin
                w_next[i] = '0;
            end else if (WR && (WADDR == AW'(i))) begin
                w_next[i] = BIN;
            end else if ((INC ^ DEC) && (CADDR == AW'(i))) begin
                if (INC) begin
                    if (&r_regs[i]) begin
                        w_ovf_ev  = 1'b1;
                        w_next[i] = (SAT != 0) ? r_regs[i] : '0;
                    end else begin
                        w_next[i] = r_regs[i] + 1'b1;
                    end
                end else begin
                    if (r_regs[i] == '0) begin
                        w_ovf_ev  = 1'b1;
                        w_next[i] = (SAT != 0) ? r_regs[i] : '1;
                    end else begin
                        w_next[i] = r_regs[i] - 1'b1;
                    end
                end
            end
        end
    end

    // Read mux. An out-of-range address selects nothing and returns zero.
    always_comb begin
        w_rdata = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (RADDR == AW'(i)) begin
                w_rdata = r_regs[i];
            end
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_bout   <= '0;
            r_bvalid <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_regs[i] <= w_next[i];
            end
            // The read samples pre-edge contents, so a same-cycle write
            // becomes visible only to the next read.
            r_bout   <= LDBUS ? w_rdata : '0;
            r_bvalid <= LDBUS;
            // A new event wins over a simultaneous clear.
            if (w_ovf_ev) begin
                r_ovf <= 1'b1;
            end else if (OVFCLR) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign BOUT   = r_bout;
    assign BVALID = r_bvalid;
    assign OVF    = r_ovf;

endmodule

// File: tb/tb_bus_reg_bank.sv
// -----------------------------------------------------------------------------
// tb_bus_reg_bank
//   Directed testbench for bus_reg_bank. It drives two instances from the
//   same stimulus:
//     u0 : WIDTH=16, DEPTH=4, SAT=0  (wrapping)
//     u1 : WIDTH=16, DEPTH=3, SAT=1  (saturating; address 3 is out of range)
//   Each scenario task checks its own expected values, which are worked out
//   by hand.
// -----------------------------------------------------------------------------
module tb_bus_reg_bank;

    logic        clk;
    logic        RST;
    logic [3:0]  CLR0;
    logic [2:0]  CLR1;
    logic        WR;
    logic [1:0]  WADDR;
    logic [15:0] BIN;
    logic        INC;
    logic        DEC;
    logic [1:0]  CADDR;
    logic        LDBUS;
    logic [1:0]  RADDR;
    logic        OVFCLR;
    logic [15:0] BOUT0, BOUT1;
    logic        BVALID0, BVALID1;
    logic        OVF0, OVF1;

    int n_cmp = 0;
    int n_err = 0;

    bus_reg_bank #(.WIDTH(16), .DEPTH(4), .SAT(0)) u0 (
        .clk(clk), .RST(RST), .CLR(CLR0), .WR(WR), .WADDR(WADDR), .BIN(BIN),
        .INC(INC), .DEC(DEC), .CADDR(CADDR), .LDBUS(LDBUS), .RADDR(RADDR),
        .OVFCLR(OVFCLR), .BOUT(BOUT0), .BVALID(BVALID0), .OVF(OVF0)
    );

    bus_reg_bank #(.WIDTH(16), .DEPTH(3), .SAT(1)) u1 (
        .clk(clk), .RST(RST), .CLR(CLR1), .WR(WR), .WADDR(WADDR), .BIN(BIN),
        .INC(INC), .DEC(DEC), .CADDR(CADDR), .LDBUS(LDBUS), .RADDR(RADDR),
        .OVFCLR(OVFCLR), .BOUT(BOUT1), .BVALID(BVALID1), .OVF(OVF1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Wait for the next rising edge, then move 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        CLR0 = '0; CLR1 = '0; WR = 1'b0; WADDR = '0; BIN = '0;
        INC = 1'b0; DEC = 1'b0; CADDR = '0; LDBUS = 1'b0; RADDR = '0;
        OVFCLR = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        WR = 1'b1; WADDR = a; BIN = d;
        tick();
        WR = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a);
        LDBUS = 1'b1; RADDR = a;
        tick();
        LDBUS = 1'b0;
    endtask

    task automatic ovfclr();
        OVFCLR = 1'b1;
        tick();
        OVFCLR = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        RST = 1'b0;
        #2 RST = 1'b1;
        #1;
        n_cmp++; if (BOUT0 !== 16'h0) begin n_err++; $display("FAIL reset_bout0: got %h want 0000", BOUT0); end
        n_cmp++; if (BVALID0 !== 1'b0) begin n_err++; $display("FAIL reset_bvalid0: got %b want 0", BVALID0); end
        n_cmp++; if (OVF0 !== 1'b0) begin n_err++; $display("FAIL reset_ovf0: got %b want 0", OVF0); end
        n_cmp++; if (OVF1 !== 1'b0) begin n_err++; $display("FAIL reset_ovf1: got %b want 0", OVF1); end
        // Inputs are ignored while reset is held.
        WR = 1'b1; WADDR = 2'd2; BIN = 16'h00FF; LDBUS = 1'b1; RADDR = 2'd2;
        INC = 1'b1; CADDR = 2'd0;
        tick(); tick();
        n_cmp++; if (BVALID0 !== 1'b0) begin n_err++; $display("FAIL reset_ignore_bvalid: got %b want 0", BVALID0); end
        idle();
        #3 RST = 1'b0;
        rd(2'd2);
        n_cmp++; if (BOUT0 !== 16'h0) begin n_err++; $display("FAIL reset_ignore_wr: got %h want 0000", BOUT0); end
        n_cmp++; if (BVALID0 !== 1'b1) begin n_err++; $display("FAIL first_edge_bvalid: got %b want 1", BVALID0); end
        rd(2'd0);
        n_cmp++; if (BOUT0 !== 16'h0) begin n_err++; $display("FAIL reset_ignore_inc: got %h want 0000", BOUT0); end
    endtask

    task automatic test_write_read();
        wr(2'd2, 16'h1234);
        rd(2'd2);
        n_cmp++; if (BOUT0 !== 16'h1234) begin n_err++; $display("FAIL wr_rd_bout0: got %h want 1234", BOUT0); end
        n_cmp++; if (BVALID0 !== 1'b1) begin n_err++; $display("FAIL wr_rd_bvalid0: got %b want 1", BVALID0); end
        n_cmp++; if (BOUT1 !== 16'h1234) begin n_err++; $display("FAIL wr_rd_bout1: got %h want 1234", BOUT1); end
        tick();
        n_cmp++; if (BOUT0 !== 16'h0) begin n_err++; $display("FAIL idle_bout0: got %h want 0000", BOUT0); end
        n_cmp++; if (BVALID0 !== 1'b0) begin n_err++; $display("FAIL idle_bvalid0: got %b want 0", BVALID0); end
    endtask

    task automatic test_wrap();
        ovfclr();
        wr(2'd1, 16'hFFFF);
        INC = 1'b1; CADDR = 2'd1;
        tick();
        INC = 1'b0;
        n_cmp++; if (OVF0 !== 1'b1) begin n_err++; $display("FAIL wrap_inc_ovf0: got %b want 1", OVF0); end
        n_cmp++; if (OVF1 !== 1'b1) begin n_err++; $display("FAIL sat_inc_ovf1: got %b want 1", OVF1); end
        rd(2'd1);
        n_cmp++; if (BOUT0 !== 16'h0000) begin n_err++; $display("FAIL wrap_inc_val: got %h want 0000", BOUT0); end
        n_cmp++; if (BOUT1 !== 16'hFFFF) begin n_err++; $display("FAIL sat_inc_val1: got %h want ffff", BOUT1); end
        ovfclr();
        n_cmp++; if (OVF0 !== 1'b0) begin n_err++; $display("FAIL ovfclr0: got %b want 0", OVF0); end
        DEC = 1'b1; CADDR = 2'd1;
        tick();
        DEC = 1'b0;
        n_cmp++; if (OVF0 !== 1'b1) begin n_err++; $display("FAIL wrap_dec_ovf0: got %b want 1", OVF0); end
        n_cmp++; if (OVF1 !== 1'b0) begin n_err++; $display("FAIL plain_dec_ovf1: got %b want 0", OVF1); end
        rd(2'd1);
        n_cmp++; if (BOUT0 !== 16'hFFFF) begin n_err++; $display("FAIL wrap_dec_val: got %h want ffff", BOUT0); end
        n_cmp++; if (BOUT1 !== 16'hFFFE) begin n_err++; $display("FAIL plain_dec_val1: got %h want fffe", BOUT1); end
    endtask

    task automatic test_saturate();
        wr(2'd0, 16'hFFFF);
        ovfclr();
        INC = 1'b1; CADDR = 2'd0;
        tick();
        INC = 1'b0;
        n_cmp++; if (OVF1 !== 1'b1) begin n_err++; $display("FAIL sat_inc_ovf: got %b want 1", OVF1); end
        rd(2'd0);
        n_cmp++; if (BOUT1 !== 16'hFFFF) begin n_err++; $display("FAIL sat_inc_hold: got %h want ffff", BOUT1); end
        n_cmp++; if (BOUT0 !== 16'h0000) begin n_err++; $display("FAIL wrap_inc_reg0: got %h want 0000", BOUT0); end
        ovfclr();
        wr(2'd0, 16'h0000);
        DEC = 1'b1; CADDR = 2'd0;
        tick();
        DEC = 1'b0;
        n_cmp++; if (OVF1 !== 1'b1) begin n_err++; $display("FAIL sat_dec_ovf: got %b want 1", OVF1); end
        rd(2'd0);
        n_cmp++; if (BOUT1 !== 16'h0000) begin n_err++; $display("FAIL sat_dec_hold: got %h want 0000", BOUT1); end
        n_cmp++; if (BOUT0 !== 16'hFFFF) begin n_err++; $display("FAIL wrap_dec_reg0: got %h want ffff", BOUT0); end
        // u0 reg0 = FFFF and u1 reg0 = 0. OVFCLR together with INC:
        // u0 overflows, so its flag must be set; u1 has no event, so its
        // flag must clear.
        ovfclr();
        INC = 1'b1; CADDR = 2'd0; OVFCLR = 1'b1;
        tick();
        INC = 1'b0; OVFCLR = 1'b0;
        n_cmp++; if (OVF0 !== 1'b1) begin n_err++; $display("FAIL set_wins_ovf0: got %b want 1", OVF0); end
        n_cmp++; if (OVF1 !== 1'b0) begin n_err++; $display("FAIL clr_no_event_ovf1: got %b want 0", OVF1); end
    endtask

    task automatic test_inc_dec_together();
        wr(2'd0, 16'hFFFF);
        ovfclr();
        INC = 1'b1; DEC = 1'b1; CADDR = 2'd0;
        tick();
        INC = 1'b0; DEC = 1'b0;
        n_cmp++; if (OVF0 !== 1'b0) begin n_err++; $display("FAIL incdec_ovf0: got %b want 0", OVF0); end
        rd(2'd0);
        n_cmp++; if (BOUT0 !== 16'hFFFF) begin n_err++; $display("FAIL incdec_hold: got %h want ffff", BOUT0); end
    endtask

    task automatic test_back_to_back();
        wr(2'd3, 16'h0009);
        WR = 1'b1; WADDR = 2'd3; BIN = 16'h0005;
        INC = 1'b1; CADDR = 2'd3;
        LDBUS = 1'b1; RADDR = 2'd3;
        tick();
        WR = 1'b0; INC = 1'b0; LDBUS = 1'b0;
        n_cmp++; if (BOUT0 !== 16'h0009) begin n_err++; $display("FAIL b2b_old_data: got %h want 0009", BOUT0); end
        n_cmp++; if (BOUT1 !== 16'h0000) begin n_err++; $display("FAIL oob_read_bout1: got %h want 0000", BOUT1); end
        n_cmp++; if (BVALID1 !== 1'b1) begin n_err++; $display("FAIL oob_read_bvalid1: got %b want 1", BVALID1); end
        rd(2'd3);
        n_cmp++; if (BOUT0 !== 16'h0005) begin n_err++; $display("FAIL b2b_wr_wins: got %h want 0005", BOUT0); end
    endtask

    task automatic test_clr();
        ovfclr();
        wr(2'd0, 16'd1);
        wr(2'd1, 16'd2);
        wr(2'd2, 16'd3);
        wr(2'd3, 16'd4);
        CLR0 = 4'b0101; CLR1 = 3'b101; INC = 1'b1; CADDR = 2'd0;
        tick();
        CLR0 = '0; CLR1 = '0; INC = 1'b0;
        rd(2'd0);
        n_cmp++; if (BOUT0 !== 16'd0) begin n_err++; $display("FAIL clr_reg0: got %h want 0000", BOUT0); end
        rd(2'd1);
        n_cmp++; if (BOUT0 !== 16'd2) begin n_err++; $display("FAIL clr_reg1: got %h want 0002", BOUT0); end
        n_cmp++; if (BOUT1 !== 16'd2) begin n_err++; $display("FAIL clr_u1_reg1: got %h want 0002", BOUT1); end
        rd(2'd2);
        n_cmp++; if (BOUT0 !== 16'd0) begin n_err++; $display("FAIL clr_reg2: got %h want 0000", BOUT0); end
        rd(2'd3);
        n_cmp++; if (BOUT0 !== 16'd4) begin n_err++; $display("FAIL clr_reg3: got %h want 0004", BOUT0); end
        n_cmp++; if (OVF0 !== 1'b0) begin n_err++; $display("FAIL clr_ovf: got %b want 0", OVF0); end
        // A clear that overrides an overflowing increment must not set OVF.
        wr(2'd0, 16'hFFFF);
        CLR0 = 4'b0001; CLR1 = 3'b001; INC = 1'b1; CADDR = 2'd0;
        tick();
        CLR0 = '0; CLR1 = '0; INC = 1'b0;
        n_cmp++; if (OVF0 !== 1'b0) begin n_err++; $display("FAIL clr_supp_ovf0: got %b want 0", OVF0); end
        n_cmp++; if (OVF1 !== 1'b0) begin n_err++; $display("FAIL clr_supp_ovf1: got %b want 0", OVF1); end
        // Write and count to different registers both take effect.
        WR = 1'b1; WADDR = 2'd1; BIN = 16'h0007; INC = 1'b1; CADDR = 2'd2;
        tick();
        WR = 1'b0; INC = 1'b0;
        rd(2'd1);
        n_cmp++; if (BOUT0 !== 16'h0007) begin n_err++; $display("FAIL split_wr: got %h want 0007", BOUT0); end
        rd(2'd2);
        n_cmp++; if (BOUT0 !== 16'h0001) begin n_err++; $display("FAIL split_inc: got %h want 0001", BOUT0); end
    endtask

    task automatic test_async_reset();
        wr(2'd1, 16'h00AA);
        wr(2'd0, 16'hFFFF);
        INC = 1'b1; CADDR = 2'd0;
        tick();
        INC = 1'b0;
        LDBUS = 1'b1; RADDR = 2'd1;
        tick();
        n_cmp++; if (BOUT0 !== 16'h00AA) begin n_err++; $display("FAIL pre_rst_bout: got %h want 00aa", BOUT0); end
        n_cmp++; if (OVF0 !== 1'b1) begin n_err++; $display("FAIL pre_rst_ovf: got %b want 1", OVF0); end
        #2 RST = 1'b1;
        #1;
        n_cmp++; if (BOUT0 !== 16'h0) begin n_err++; $display("FAIL async_bout: got %h want 0000", BOUT0); end
        n_cmp++; if (BVALID0 !== 1'b0) begin n_err++; $display("FAIL async_bvalid: got %b want 0", BVALID0); end
        n_cmp++; if (OVF0 !== 1'b0) begin n_err++; $display("FAIL async_ovf: got %b want 0", OVF0); end
        n_cmp++; if (BVALID1 !== 1'b0) begin n_err++; $display("FAIL async_bvalid1: got %b want 0", BVALID1); end
        #2 RST = 1'b0;
        // LDBUS is still high, so the first edge after release reads reg1.
        tick();
        LDBUS = 1'b0;
        n_cmp++; if (BOUT0 !== 16'h0) begin n_err++; $display("FAIL post_rst_reg1: got %h want 0000", BOUT0); end
        n_cmp++; if (BVALID0 !== 1'b1) begin n_err++; $display("FAIL post_rst_bvalid: got %b want 1", BVALID0); end
        rd(2'd0);
        n_cmp++; if (BOUT0 !== 16'h0) begin n_err++; $display("FAIL post_rst_reg0: got %h want 0000", BOUT0); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_wrap();
        test_saturate();
        test_inc_dec_together();
        test_back_to_back();
        test_clr();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bus_reg_bank.md
BUS_REG_BANK -- requirements
Module: bus_reg_bank

Interface
REQ-001 Parameter WIDTH, default 16: data width of each register and of the bus.
REQ-002 Parameter DEPTH, default 4: number of registers, legal range 2..16.
REQ-003 Parameter SAT, default 0: 0 = wrapping increment/decrement, 1 = saturating.
REQ-004 AW SHALL be derived as clog2(DEPTH), and SHALL be at least 1.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 RST  in  1  reset, asynchronous and active-high.
REQ-007 CLR  in  DEPTH  synchronous per-register clear, one bit per register.
REQ-008 WR  in  1  write enable.
REQ-009 WADDR  in  AW  write address.
REQ-010 BIN  in  WIDTH  write data from the bus.
REQ-011 INC  in  1  increment request.
REQ-012 DEC  in  1  decrement request.
REQ-013 CADDR  in  AW  increment/decrement target address.
REQ-014 LDBUS  in  1  bus read request.
REQ-015 RADDR  in  AW  read address.
REQ-016 OVFCLR  in  1  clears the sticky overflow flag.
REQ-017 BOUT  out  WIDTH  registered read data.
REQ-018 BVALID  out  1  BOUT holds valid read data.
REQ-019 OVF  out  1  sticky overflow/underflow flag.

Function
REQ-020 Per-register next-state priority SHALL be, highest first: RST, CLR[i], WR to i, INC/DEC to i, hold.
REQ-021 WR with WADDR=i SHALL load BIN into register i at the clock edge.
REQ-022 INC alone with CADDR=i SHALL set register i to reg+1; DEC alone SHALL set it to reg-1, modulo 2^WIDTH.
REQ-023 INC and DEC asserted together SHALL leave the register unchanged and SHALL NOT affect OVF.
REQ-024 WR and INC/DEC to the same register in one cycle: WR SHALL win and the count SHALL be discarded, with no OVF effect.
REQ-025 WR and INC/DEC to different registers in one cycle SHALL both take effect.
REQ-026 SAT=0: INC at all-ones SHALL wrap to 0, and DEC at 0 SHALL wrap to all-ones; both SHALL set OVF.
REQ-027 SAT=1: INC at all-ones and DEC at 0 SHALL hold the value and SHALL set OVF.
REQ-028 OVF SHALL be sticky until OVFCLR or RST.
REQ-029 If OVFCLR coincides with a new overflow event, OVF SHALL remain 1 (set wins).
REQ-030 A CLR[i] that suppresses a count to register i SHALL cause no OVF effect.
REQ-031 Read latency SHALL be 1 cycle: when LDBUS=1 at edge k, BOUT SHALL equal register RADDR as sampled before edge k, and BVALID SHALL be 1 after edge k.
REQ-032 Reads SHALL return old data on a same-cycle write to the same address; the new value SHALL be visible from the next read.
REQ-033 When LDBUS=0 at an edge, BOUT SHALL be 0 and BVALID 0 after that edge; BOUT SHALL never be high-impedance.
REQ-034 Addresses at or above DEPTH: writes and counts SHALL be ignored; reads SHALL return BOUT=0 with BVALID=1.
REQ-035 BOUT, BVALID and OVF SHALL be driven directly from flops with no combinational path from inputs.

Reset
REQ-036 RST=1 SHALL immediately, without a clock, force all registers, BOUT, BVALID and OVF to 0.
REQ-037 While RST=1, all other inputs SHALL be ignored.
REQ-038 The first edge after RST falls SHALL operate normally.
REQ-039 RST asserted mid-count or mid-read SHALL discard the operation and produce no BVALID pulse.
REQ-040 CLR SHALL act only at clock edges and SHALL NOT reset BOUT, BVALID or OVF.

Verification
REQ-041 WR WADDR=2 BIN=0x1234, next cycle LDBUS RADDR=2 -> after the following edge BOUT=0x1234, BVALID=1; with LDBUS=0 afterwards -> BOUT=0, BVALID=0.
REQ-042 SAT=0, reg1=0xFFFF, INC CADDR=1 -> reg1=0x0000 and OVF=1; OVFCLR -> OVF=0; DEC at 0 -> 0xFFFF and OVF=1.
REQ-043 SAT=1, reg0=0xFFFF, INC -> reg0 stays 0xFFFF with OVF=1; reg0=0, DEC -> stays 0 with OVF=1.
REQ-044 Same cycle: WR WADDR=3 BIN=5, INC CADDR=3, LDBUS RADDR=3 with old reg3=9 -> BOUT=9, then reg3=5 (not 6).
REQ-045 reg0..3 = 1,2,3,4; CLR=4'b0101 with INC CADDR=0 -> registers 0,2,0,4 and OVF unchanged.
REQ-046 RST pulsed between clock edges while BVALID=1 and OVF=1 -> BOUT, BVALID, OVF and all registers read 0 before the next edge.
